ahbl_sram_slave: RTL and testbench
==================================

# ahbl_sram_slave

AHB-Lite subordinate that terminates one HSEL slot of the AHB-Lite bus mux and serves a synchronous single-port SRAM with one-cycle read latency. It captures the address phase into a registered `aphase_t`, generates SRAM byte strobes, inserts one wait state on reads, and returns the two-cycle AHB ERROR response for illegal transfers. It is the responder end of the fabric the bus mux initiates into.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte base address of the window; must be 4-byte aligned.
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; `AW = $clog2(MEM_WORDS)`.
- `HCLK` in 1: clock; everything is rising-edge.
- `HRESETn` in 1: asynchronous active-low reset.
- `HSEL` in 1: slot select from the decoder.
- `HADDR` in 32: address-phase byte address.
- `HBURST` in 3, `HMASTLOCK` in 1, `HPROT` in 4: captured into `aphase_t`; no functional effect.
- `HSIZE` in 3: transfer size; 0, 1 and 2 are legal.
- `HTRANS` in 2: IDLE/BUSY/NONSEQ/SEQ per `ahbl_bus_mux_defines`.
- `HWRITE` in 1: 1 means write.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready from the mux.
- `HREADYOUT` out 1: this subordinate's ready.
- `HRESP` out 1: 0 means OKAY, 1 means ERROR.
- `HRDATA` out 32: read data.
- `sram_en` out 1: SRAM access strobe.
- `sram_wen` out 1: 1 means write.
- `sram_addr` out AW: word address, `(HADDR-BASE_ADDR)>>2`.
- `sram_be` out 4: byte enables; bit n covers `wdata[8n+7:8n]`.
- `sram_wdata` out 32: `HWDATA` passed straight through.
- `sram_rdata` in 32: valid the cycle after a read `sram_en`.

## Operation
- **Address capture:** when `HSEL && HREADY && HTRANS[1]`, latch the address phase into an `aphase_t` register plus an `err` flag.
  - IDLE or BUSY transfers, or `!HSEL`, capture nothing and get a zero-wait OKAY.
- **`err` flag** is set if any of these hold:
  - `(HADDR - BASE_ADDR)` as unsigned 32-bit is ≥ `MEM_WORDS*4`;
  - `HSIZE > 2`;
  - `HSIZE==1 && HADDR[0]`;
  - `HSIZE==2 && HADDR[1:0]!=0`.
- **Byte enables** (little-endian, from the captured phase):
  - size 0: `1<<addr[1:0]`;
  - size 1: `addr[1] ? 4'b1100 : 4'b0011`;
  - size 2: `4'b1111`.
- **FSM states:** IDLE, WRITE, RD_ISSUE, RD_DONE, ERR1, ERR2.
  - From any state whose data phase is completing (HREADYOUT=1), a capture goes to ERR1 if `err`, WRITE if write, RD_ISSUE if read; with no capture it goes to IDLE.
  - WRITE: `sram_en=1`, `sram_wen=1`, `sram_addr`/`sram_be` from the capture, `sram_wdata=HWDATA`, HREADYOUT=1, HRESP=0.
  - RD_ISSUE: `sram_en=1`, `sram_wen=0`, HREADYOUT=0. The next state is always RD_DONE, and no capture happens because HREADY is low.
  - RD_DONE: `HRDATA=sram_rdata`, HREADYOUT=1, `sram_en=0`.
  - ERR1: HRESP=1, HREADYOUT=0, next state ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. The SRAM is never accessed in either error state.
  - IDLE: HREADYOUT=1, HRESP=0, `sram_en=0`.
- `HRDATA` is 0 in every state other than RD_DONE.
- `HBURST` is not interpreted: every beat is decoded independently, so INCR/WRAP bursts work beat by beat.

## Timing
- **Reset values:**
  - state IDLE, captured phase 0;
  - `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`;
  - `sram_en=0`, `sram_wen=0`, `sram_addr=0`, `sram_be=0`.
  - `sram_wdata` follows `HWDATA` at all times.
- **Latency:**
  - writes: zero wait states, SRAM written in the first data-phase cycle;
  - reads: exactly one wait state, data returned in the second data-phase cycle;
  - errors: exactly two data-phase cycles.
- **Back-to-back:** pipelined transfers are captured in the last data-phase cycle, i.e. WRITE, RD_DONE or ERR2 with HREADYOUT=1.
  - A read immediately after a write to the same word returns the new data, because the write completes before RD_ISSUE.
- **ERR2 cancel:** a manager that switches HTRANS to IDLE in ERR2 cancels the following transfer; nothing is captured.
- **HSEL low with HREADY high** behaves as IDLE. HREADYOUT stays 1 whenever no data phase is owned.
- **Reset mid-operation:** asserting `HRESETn` low during RD_ISSUE or ERR1 drops `sram_en` and forces `HREADYOUT=1` and `HRESP=0` asynchronously, without waiting for a clock edge.
- **Address arithmetic:** wraps at 32 bits, so addresses below `BASE_ADDR` are out of range. `sram_addr` is the low AW bits of the word offset.

## Test plan
- **Write then read:** with `BASE_ADDR=0x2000`, write word `0xDEADBEEF` to 0x2004, then read 0x2004.
  - The write completes with no wait state: `sram_be=4'hF`, `sram_addr=1`.
  - The read shows HREADYOUT=0 for one cycle, then `HRDATA=0xDEADBEEF` with OKAY.
- **Byte write:** write a byte to 0x2007 with `HWDATA=0xAA000000`.
  - Required: `sram_be=4'b1000`.
  - A subsequent word read returns `0xAAADBEEF`.
- **Out-of-range address:** transfer to 0x1FFC and to `0x2000+MEM_WORDS*4`.
  - Required: two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 in both cycles) and `sram_en` never asserted.
- **Illegal size/alignment:** halfword at 0x2001, word at 0x2002, and `HSIZE=3`.
  - Each gives a two-cycle ERROR with no SRAM access.
- **Pipelined burst with BUSY:** INCR4 read at 0x2010 with one BUSY inserted after beat 2.
  - Required: four data phases of 2 cycles each, the BUSY answered with a zero-wait OKAY, and `sram_addr` sequence 4, 5, 6, 7.
- **Reset mid-read:** drive `HRESETn` low during RD_ISSUE.
  - Required: same-cycle `HREADYOUT=1`, `sram_en=0`, `HRDATA=0`.
  - After release the block is IDLE and the next read behaves normally.

Source files
------------

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM with one-cycle read latency.
// Writes complete with no wait state, reads take one wait state, and illegal transfers get a two-cycle ERROR.
module ahbl_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  localparam int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [2:0]    HBURST,
  input  logic          HMASTLOCK,
  input  logic [3:0]    HPROT,
  input  logic [2:0]    HSIZE,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          sram_en,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_be,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  // state      | meaning
  // S_IDLE     | no data phase owned, zero-wait OKAY
  // S_WRITE    | write data phase, SRAM written this cycle
  // S_RD_ISSUE | read wait state, SRAM read issued
  // S_RD_DONE  | read data returned from SRAM
  // S_ERR1     | first ERROR cycle (HREADYOUT low)
  // S_ERR2     | second ERROR cycle (HREADYOUT high)
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_DONE, S_ERR1, S_ERR2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
  } aphase_t;

  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);

  state_t          state, state_nxt;
  aphase_t         aphase_d, aphase_q;
  logic            err_d, err_q;
  logic            capture, take;
  logic [31:0]     offset;
  logic [3:0]      be_d;
  logic            hreadyout_q, hresp_q, sram_en_q, sram_wen_q, rd_done_q;
  logic [AW-1:0]   sram_addr_q;
  logic [3:0]      sram_be_q;

  assign capture = HSEL && HREADY && HTRANS[1];
  // In the two stall states HREADY is low, so no new address phase can be accepted.
  assign take    = capture && !(state inside {S_RD_ISSUE, S_ERR1});
  assign offset  = HADDR - BASE_ADDR;

  assign aphase_d = '{addr: HADDR, size: HSIZE, write: HWRITE, trans: HTRANS,
                      burst: HBURST, prot: HPROT, mastlock: HMASTLOCK};

  assign err_d = (offset >= WIN_BYTES) || (HSIZE > 3'd2) ||
                 (HSIZE == 3'd1 && HADDR[0]) ||
                 (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  always_comb begin
    be_d = 4'b0000;
    case (aphase_d.size)
      3'd0:    be_d = 4'b0001 << aphase_d.addr[1:0];
      3'd1:    be_d = aphase_d.addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_RD_ISSUE: state_nxt = S_RD_DONE;
      S_ERR1:     state_nxt = S_ERR2;
      default: begin
        if (take) begin
          if (err_d)       state_nxt = S_ERR1;
          else if (HWRITE) state_nxt = S_WRITE;
          else             state_nxt = S_RD_ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      aphase_q    <= '0;
      err_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      sram_en_q   <= 1'b0;
      sram_wen_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_be_q   <= 4'b0000;
    end else begin
      state       <= state_nxt;
      hreadyout_q <= !(state_nxt inside {S_RD_ISSUE, S_ERR1});
      hresp_q     <= state_nxt inside {S_ERR1, S_ERR2};
      sram_en_q   <= state_nxt inside {S_WRITE, S_RD_ISSUE};
      sram_wen_q  <= state_nxt == S_WRITE;
      rd_done_q   <= state_nxt == S_RD_DONE;
      if (take) begin
        aphase_q <= aphase_d;
        err_q    <= err_d;
      end
      // SRAM address/strobes only move for legal transfers; errors never touch the array.
      if (take && !err_d) begin
        sram_addr_q <= offset[AW+1:2];
        sram_be_q   <= be_d;
      end
    end
  end

  assign HREADYOUT  = hreadyout_q;
  assign HRESP      = hresp_q;
  assign HRDATA     = rd_done_q ? sram_rdata : 32'h0;
  assign sram_en    = sram_en_q;
  assign sram_wen   = sram_wen_q;
  assign sram_addr  = sram_addr_q;
  assign sram_be    = sram_be_q;
  assign sram_wdata = HWDATA;

  // Protection/burst attributes are recorded for observability but have no functional effect.
  logic unused_aphase;
  assign unused_aphase = ^{aphase_q, err_q};

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed self-checking bench for ahbl_sram_slave with a behavioural SRAM model.
// Single subordinate on the bus, so HREADY is looped back from HREADYOUT.
module tb_ahbl_sram_slave;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int WORDS = 1024;
  localparam int AW = 10;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = 32'h0;
  logic [2:0]    HBURST = 3'b000;
  logic          HMASTLOCK = 1'b0;
  logic [3:0]    HPROT = 4'h3;
  logic [2:0]    HSIZE = 3'd2;
  logic [1:0]    HTRANS = T_IDLE;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADY;
  logic          HREADYOUT, HRESP;
  logic [31:0]   HRDATA;
  logic          sram_en, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  int n_chk = 0;
  int n_ok  = 0;

  bit [31:0] mem [WORDS];

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahbl_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_be(sram_be), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always @(posedge HCLK) begin
    if (sram_en) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr;
  endtask

  task automatic test_reset;
    HWDATA = 32'h5A5A_A5A5;
    #2 HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    n_chk++; if (HREADYOUT !== 1'b1) $display("FAIL rst_hreadyout got %b want 1", HREADYOUT); else n_ok++;
    n_chk++; if (HRESP !== 1'b0) $display("FAIL rst_hresp got %b want 0", HRESP); else n_ok++;
    n_chk++; if (HRDATA !== 32'h0) $display("FAIL rst_hrdata got %h want 0", HRDATA); else n_ok++;
    n_chk++; if (sram_en !== 1'b0 || sram_wen !== 1'b0) $display("FAIL rst_sram_en got %b/%b want 0/0", sram_en, sram_wen); else n_ok++;
    n_chk++; if (sram_addr !== 10'h0 || sram_be !== 4'h0) $display("FAIL rst_addr_be got %h/%h want 0/0", sram_addr, sram_be); else n_ok++;
    n_chk++; if (sram_wdata !== 32'h5A5A_A5A5) $display("FAIL rst_wdata got %h want 5a5aa5a5", sram_wdata); else n_ok++;
    HRESETn = 1'b1;
    tick;
  endtask

  task automatic test_write_read;
    drive(32'h2004, 1'b1, 3'd2, T_NS);
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) $display("FAIL wr_nowait got rdy=%b resp=%b want 1/0", HREADYOUT, HRESP); else n_ok++;
    n_chk++; if (sram_en !== 1'b1 || sram_wen !== 1'b1) $display("FAIL wr_strobe got %b/%b want 1/1", sram_en, sram_wen); else n_ok++;
    n_chk++; if (sram_be !== 4'hF || sram_addr !== 10'd1) $display("FAIL wr_be_addr got %h/%0d want f/1", sram_be, sram_addr); else n_ok++;
    HWDATA = 32'hDEAD_BEEF;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    #1;
    n_chk++; if (sram_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_wdata got %h want deadbeef", sram_wdata); else n_ok++;
    tick;
    n_chk++; if (HREADYOUT !== 1'b0) $display("FAIL rd_wait got %b want 0", HREADYOUT); else n_ok++;
    n_chk++; if (sram_en !== 1'b1 || sram_wen !== 1'b0 || sram_addr !== 10'd1) $display("FAIL rd_issue got en=%b wen=%b addr=%0d want 1/0/1", sram_en, sram_wen, sram_addr); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) $display("FAIL rd_done_rdy got %b/%b want 1/0", HREADYOUT, HRESP); else n_ok++;
    n_chk++; if (HRDATA !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", HRDATA); else n_ok++;
    n_chk++; if (sram_en !== 1'b0) $display("FAIL rd_done_en got %b want 0", sram_en); else n_ok++;
    tick;
    n_chk++; if (HRDATA !== 32'h0 || HREADYOUT !== 1'b1) $display("FAIL idle_after_rd got %h/%b want 0/1", HRDATA, HREADYOUT); else n_ok++;
  endtask

  task automatic test_byte_write;
    drive(32'h2007, 1'b1, 3'd0, T_NS);
    tick;
    n_chk++; if (sram_be !== 4'b1000 || sram_addr !== 10'd1) $display("FAIL byte_be got %b/%0d want 1000/1", sram_be, sram_addr); else n_ok++;
    HWDATA = 32'hAA00_0000;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    tick;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'hAAAD_BEEF) $display("FAIL byte_rd got %h want aaadbeef", HRDATA); else n_ok++;
    drive(32'h2002, 1'b1, 3'd1, T_NS);
    tick;
    n_chk++; if (sram_be !== 4'b1100 || sram_addr !== 10'd0) $display("FAIL half_be got %b/%0d want 1100/0", sram_be, sram_addr); else n_ok++;
    HWDATA = 32'h1234_0000;
    drive(32'h2FFF, 1'b1, 3'd0, T_NS);
    tick;
    n_chk++; if (sram_en !== 1'b1 || sram_be !== 4'b1000 || sram_addr !== 10'h3FF) $display("FAIL top_byte got en=%b be=%b addr=%h want 1/1000/3ff", sram_en, sram_be, sram_addr); else n_ok++;
    HWDATA = 32'h7700_0000;
    drive(32'h2000, 1'b0, 3'd2, T_NS);
    tick;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'h1234_0000) $display("FAIL half_rd got %h want 12340000", HRDATA); else n_ok++;
    drive(32'h2FFC, 1'b0, 3'd2, T_NS);
    tick;
    n_chk++; if (sram_addr !== 10'h3FF || HREADYOUT !== 1'b0) $display("FAIL top_rd_issue got %h/%b want 3ff/0", sram_addr, HREADYOUT); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'h7700_0000) $display("FAIL top_rd got %h want 77000000", HRDATA); else n_ok++;
    tick;
  endtask

  task automatic test_errors;
    logic [31:0] ea [5] = '{32'h1FFC, 32'h3000, 32'h2001, 32'h2002, 32'h2000};
    logic [2:0]  es [5] = '{3'd2, 3'd2, 3'd1, 3'd2, 3'd3};
    logic        ew [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ea[i], ew[i], es[i], T_NS);
      tick;
      n_chk++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || sram_en !== 1'b0) $display("FAIL err1_%0d got rdy=%b resp=%b en=%b want 0/1/0", i, HREADYOUT, HRESP, sram_en); else n_ok++;
      HTRANS = T_IDLE;
      HWDATA = 32'hFFFF_FFFF;
      tick;
      n_chk++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || sram_en !== 1'b0) $display("FAIL err2_%0d got rdy=%b resp=%b en=%b want 1/1/0", i, HREADYOUT, HRESP, sram_en); else n_ok++;
      tick;
      n_chk++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) $display("FAIL err_end_%0d got resp=%b rdy=%b want 0/1", i, HRESP, HREADYOUT); else n_ok++;
    end
    drive(32'h2000, 1'b0, 3'd2, T_NS);
    tick;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'h1234_0000) $display("FAIL err_no_write got %h want 12340000", HRDATA); else n_ok++;
    tick;
  endtask

  task automatic test_err2_cancel;
    drive(32'h2001, 1'b0, 3'd2, T_NS);
    tick;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    tick;
    n_chk++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) $display("FAIL cancel_err2 got %b/%b want 1/1", HRESP, HREADYOUT); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (sram_en !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) $display("FAIL cancel_idle got en=%b rdy=%b resp=%b want 0/1/0", sram_en, HREADYOUT, HRESP); else n_ok++;
    drive(32'h2001, 1'b0, 3'd2, T_NS);
    tick;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    tick;
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_en !== 1'b1 || sram_addr !== 10'd1 || HRESP !== 1'b0) $display("FAIL err2_pipe got rdy=%b en=%b addr=%0d resp=%b want 0/1/1/0", HREADYOUT, sram_en, sram_addr, HRESP); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'hAAAD_BEEF) $display("FAIL err2_pipe_data got %h want aaadbeef", HRDATA); else n_ok++;
    tick;
  endtask

  task automatic test_hsel_idle;
    HSEL = 1'b0; HTRANS = T_NS; HWRITE = 1'b1; HADDR = 32'h2004;
    tick;
    n_chk++; if (sram_en !== 1'b0 || HREADYOUT !== 1'b1) $display("FAIL hsel_low got en=%b rdy=%b want 0/1", sram_en, HREADYOUT); else n_ok++;
    HSEL = 1'b1; HTRANS = T_BUSY;
    tick;
    n_chk++; if (sram_en !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) $display("FAIL busy_okay got en=%b rdy=%b resp=%b want 0/1/0", sram_en, HREADYOUT, HRESP); else n_ok++;
    HTRANS = T_IDLE;
    tick;
  endtask

  task automatic test_back_to_back;
    HBURST = 3'b011;
    drive(32'h2010, 1'b1, 3'd2, T_NS);
    tick;
    for (int i = 1; i <= 4; i++) begin
      n_chk++; if (sram_en !== 1'b1 || sram_wen !== 1'b1 || sram_addr !== 10'(3 + i) || HREADYOUT !== 1'b1) $display("FAIL bwr_%0d got en=%b wen=%b addr=%0d rdy=%b want 1/1/%0d/1", i, sram_en, sram_wen, sram_addr, HREADYOUT, 3 + i); else n_ok++;
      HWDATA = 32'hC0DE_0000 + 32'(i - 1);
      if (i < 4) drive(32'h2010 + 32'(4 * i), 1'b1, 3'd2, T_SEQ);
      else HTRANS = T_IDLE;
      tick;
    end
    drive(32'h2010, 1'b0, 3'd2, T_NS);
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_addr !== 10'd4) $display("FAIL brd_iss0 got %b/%0d want 0/4", HREADYOUT, sram_addr); else n_ok++;
    drive(32'h2014, 1'b0, 3'd2, T_SEQ);
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hC0DE_0000) $display("FAIL brd_dat0 got %b/%h want 1/c0de0000", HREADYOUT, HRDATA); else n_ok++;
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_addr !== 10'd5) $display("FAIL brd_iss1 got %b/%0d want 0/5", HREADYOUT, sram_addr); else n_ok++;
    drive(32'h2018, 1'b0, 3'd2, T_BUSY);
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hC0DE_0001) $display("FAIL brd_dat1 got %b/%h want 1/c0de0001", HREADYOUT, HRDATA); else n_ok++;
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || sram_en !== 1'b0 || HRDATA !== 32'h0) $display("FAIL brd_busy got rdy=%b resp=%b en=%b data=%h want 1/0/0/0", HREADYOUT, HRESP, sram_en, HRDATA); else n_ok++;
    drive(32'h2018, 1'b0, 3'd2, T_SEQ);
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_addr !== 10'd6) $display("FAIL brd_iss2 got %b/%0d want 0/6", HREADYOUT, sram_addr); else n_ok++;
    drive(32'h201C, 1'b0, 3'd2, T_SEQ);
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hC0DE_0002) $display("FAIL brd_dat2 got %b/%h want 1/c0de0002", HREADYOUT, HRDATA); else n_ok++;
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_addr !== 10'd7) $display("FAIL brd_iss3 got %b/%0d want 0/7", HREADYOUT, sram_addr); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hC0DE_0003) $display("FAIL brd_dat3 got %b/%h want 1/c0de0003", HREADYOUT, HRDATA); else n_ok++;
    HBURST = 3'b000;
    tick;
  endtask

  task automatic test_reset_mid;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_en !== 1'b1) $display("FAIL mrst_pre got %b/%b want 0/1", HREADYOUT, sram_en); else n_ok++;
    HTRANS = T_IDLE;
    #2 HRESETn = 1'b0;
    #1;
    n_chk++; if (HREADYOUT !== 1'b1 || sram_en !== 1'b0 || HRDATA !== 32'h0 || HRESP !== 1'b0) $display("FAIL mrst_async got rdy=%b en=%b data=%h resp=%b want 1/0/0/0", HREADYOUT, sram_en, HRDATA, HRESP); else n_ok++;
    tick;
    HRESETn = 1'b1;
    tick;
    n_chk++; if (HREADYOUT !== 1'b1 || sram_en !== 1'b0 || HRDATA !== 32'h0) $display("FAIL mrst_idle got rdy=%b en=%b data=%h want 1/0/0", HREADYOUT, sram_en, HRDATA); else n_ok++;
    drive(32'h2004, 1'b0, 3'd2, T_NS);
    tick;
    n_chk++; if (HREADYOUT !== 1'b0 || sram_en !== 1'b1 || sram_addr !== 10'd1) $display("FAIL mrst_reread got rdy=%b en=%b addr=%0d want 0/1/1", HREADYOUT, sram_en, sram_addr); else n_ok++;
    HTRANS = T_IDLE;
    tick;
    n_chk++; if (HRDATA !== 32'hAAAD_BEEF) $display("FAIL mrst_data got %h want aaadbeef", HRDATA); else n_ok++;
    drive(32'h3000, 1'b0, 3'd2, T_NS);
    tick;
    HTRANS = T_IDLE;
    #2 HRESETn = 1'b0;
    #1;
    n_chk++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) $display("FAIL mrst_err got resp=%b rdy=%b want 0/1", HRESP, HREADYOUT); else n_ok++;
    tick;
    HRESETn = 1'b1;
    tick;
    n_chk++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) $display("FAIL mrst_err_after got resp=%b rdy=%b want 0/1", HRESP, HREADYOUT); else n_ok++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_write_read;
    test_byte_write;
    test_errors;
    test_err2_cancel;
    test_hsel_idle;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
